// File: rtl/dm_unit.sv
// Data memory stage for the single-cycle MIPS datapath: combinational loads with
// lane extraction and extension, edge-committed stores, alignment and range flags.
module dm_unit #(
  parameter int WORD_AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [2:0]  mem_op,
  output logic [31:0] rdata,
  output logic        align_err,
  output logic        range_err
);

  localparam int DEPTH = 1 << WORD_AW;

  localparam logic [2:0] OP_WORD = 3'b000;
  localparam logic [2:0] OP_HU   = 3'b001;
  localparam logic [2:0] OP_HS   = 3'b010;
  localparam logic [2:0] OP_BU   = 3'b011;
  localparam logic [2:0] OP_BS   = 3'b100;

  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        mem_d [DEPTH];

  logic [WORD_AW-1:0] idx;
  logic               is_word, is_half, is_byte;
  logic               misaligned, out_of_range, commit;
  logic [31:0]        rd_word, wr_word;
  logic [15:0]        half_sel;
  logic [7:0]         byte_sel;

  assign idx     = addr[WORD_AW+1:2];
  assign rd_word = mem_q[idx];
  assign is_word = (mem_op == OP_WORD);
  assign is_half = (mem_op == OP_HU) || (mem_op == OP_HS);
  assign is_byte = (mem_op == OP_BU) || (mem_op == OP_BS);

  // Reserved ops fall through all three classes and are reported as misaligned.
  assign misaligned   = !(is_word || is_half || is_byte)
                      || (is_word && (addr[1:0] != 2'b00))
                      || (is_half && addr[0]);
  assign out_of_range = |addr[31:WORD_AW+2];
  assign commit       = we && !reset && !misaligned && !out_of_range;

  assign align_err = misaligned && !reset;
  assign range_err = out_of_range && !reset;

  always_comb begin
    half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];
    byte_sel = rd_word[8*addr[1:0] +: 8];
    rdata    = '0;
    if (!reset && !misaligned && !out_of_range) begin
      case (mem_op)
        OP_WORD: rdata = rd_word;
        OP_HU:   rdata = {16'h0000, half_sel};
        OP_HS:   rdata = {{16{half_sel[15]}}, half_sel};
        OP_BU:   rdata = {24'h000000, byte_sel};
        OP_BS:   rdata = {{24{byte_sel[7]}}, byte_sel};
        default: rdata = '0;
      endcase
    end
  end

  // Merge store data into the current word so partial stores keep other lanes.
  always_comb begin
    wr_word = rd_word;
    if (is_word) begin
      wr_word = wdata;
    end else if (is_half) begin
      if (addr[1]) wr_word[31:16] = wdata[15:0];
      else         wr_word[15:0]  = wdata[15:0];
    end else if (is_byte) begin
      wr_word[8*addr[1:0] +: 8] = wdata[7:0];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (commit) mem_d[idx] = wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (commit) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, wr_word);
  end
`endif

endmodule

// File: tb/tb_dm_unit.sv
// Directed bench for dm_unit: hand-computed expectations checked with immediate assertions.
module tb_dm_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, addr, wdata;
  logic        we;
  logic [2:0]  mem_op;
  logic [31:0] rdata;
  logic        align_err, range_err;

  int n_tests = 0;
  int n_fail  = 0;

  dm_unit #(.WORD_AW(10)) dut (
    .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wdata(wdata),
    .we(we), .mem_op(mem_op), .rdata(rdata),
    .align_err(align_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    @(negedge clk);
    addr = a; wdata = d; mem_op = op; we = 1'b1; pc = pc + 32'd4;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] op,
                      input logic [31:0] exp);
    addr = a; mem_op = op; we = 1'b0;
    #1 check(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0040_0000; addr = 32'h22; wdata = '0; we = 1'b0; mem_op = 3'b000;
    #2;
    check("rst_rdata", rdata, 32'h0);
    check("rst_align", {31'b0, align_err}, 32'h0);
    addr = 32'h0000_1000;
    #1 check("rst_range", {31'b0, range_err}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Word store then byte/half extraction
    store(32'h20, 32'h1234_5678, 3'b000);
    load("lbu_20", 32'h20, 3'b011, 32'h0000_0078);
    load("lbu_21", 32'h21, 3'b011, 32'h0000_0056);
    load("lbu_22", 32'h22, 3'b011, 32'h0000_0034);
    load("lbu_23", 32'h23, 3'b011, 32'h0000_0012);
    load("lh_22",  32'h22, 3'b010, 32'h0000_1234);
    load("lw_20",  32'h20, 3'b000, 32'h1234_5678);

    // Byte store merges into a zero word
    store(32'h40, 32'h0000_0000, 3'b000);
    store(32'h41, 32'hFFFF_FF80, 3'b011);
    load("lw_40_sb",  32'h40, 3'b000, 32'h0000_8000);
    load("lb_41",     32'h41, 3'b100, 32'hFFFF_FF80);
    load("lbu_41",    32'h41, 3'b011, 32'h0000_0080);

    // Half store preserves the other half
    store(32'h40, 32'h1111_2222, 3'b000);
    store(32'h42, 32'h0000_ABCD, 3'b001);
    load("lw_40_sh", 32'h40, 3'b000, 32'hABCD_2222);
    load("lh_42",    32'h42, 3'b010, 32'hFFFF_ABCD);
    load("lhu_42",   32'h42, 3'b001, 32'h0000_ABCD);
    load("lh_40",    32'h40, 3'b010, 32'h0000_2222);
    store(32'h43, 32'h0000_0077, 3'b100);
    load("lw_40_sb3", 32'h40, 3'b000, 32'h77CD_2222);

    // Misaligned and reserved accesses
    @(negedge clk);
    addr = 32'h22; wdata = 32'hDEAD_BEEF; mem_op = 3'b000; we = 1'b1;
    #1 check("sw_22_align", {31'b0, align_err}, 32'h1);
    check("sw_22_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 we = 1'b0;
    load("lw_20_kept", 32'h20, 3'b000, 32'h1234_5678);
    load("lh_21_rdata", 32'h21, 3'b010, 32'h0);
    check("lh_21_align", {31'b0, align_err}, 32'h1);
    load("lbu_21_ok", 32'h21, 3'b011, 32'h0000_0056);
    check("lbu_21_align", {31'b0, align_err}, 32'h0);
    load("rsv_20_rdata", 32'h20, 3'b101, 32'h0);
    check("rsv_20_align", {31'b0, align_err}, 32'h1);

    // Out-of-range accesses and the top boundary
    store(32'h0, 32'h0BAD_F00D, 3'b000);
    @(negedge clk);
    addr = 32'h0000_1000; wdata = 32'hCAFE_BABE; mem_op = 3'b000; we = 1'b1;
    #1 check("sw_1000_range", {31'b0, range_err}, 32'h1);
    check("sw_1000_rdata", rdata, 32'h0);
    @(posedge clk);
    #1 we = 1'b0;
    load("lw_0_kept", 32'h0, 3'b000, 32'h0BAD_F00D);
    load("lw_8000_rdata", 32'h8000_0000, 3'b000, 32'h0);
    check("lw_8000_range", {31'b0, range_err}, 32'h1);
    store(32'hFFC, 32'hA5A5_0001, 3'b000);
    load("lw_ffc", 32'hFFC, 3'b000, 32'hA5A5_0001);
    check("lw_ffc_range", {31'b0, range_err}, 32'h0);

    // Read during write: old value before the edge, new after
    @(negedge clk);
    addr = 32'h30; wdata = 32'h55AA_55AA; mem_op = 3'b000; we = 1'b1;
    #1 check("rdw_before", rdata, 32'h0);
    @(posedge clk);
    #1 check("rdw_after", rdata, 32'h55AA_55AA);
    we = 1'b0;

    // Reset mid-run clears memory and blocks writes
    #2 reset = 1'b1;
    addr = 32'h20; wdata = 32'hFFFF_FFFF; mem_op = 3'b000; we = 1'b1;
    #1 check("mid_rst_rdata", rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 check("mid_rst_rdata2", rdata, 32'h0);
    addr = 32'h21;
    #1 check("mid_rst_align", {31'b0, align_err}, 32'h0);
    @(negedge clk);
    we = 1'b0; reset = 1'b0;
    load("post_rst_10", 32'h10, 3'b000, 32'h0);
    load("post_rst_20", 32'h20, 3'b000, 32'h0);
    load("post_rst_40", 32'h40, 3'b000, 32'h0);
    load("post_rst_30", 32'h30, 3'b000, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data memory stage directly downstream of the ALU in the single-cycle MIPS datapath.
- The ALU result C is used as the byte address for lw/lh/lhu/lb/lbu/sw/sh/sb.
- Stores commit on the clock edge. Loads are combinational, with byte/half extraction and sign/zero extension.
- Flags misaligned and out-of-range accesses to the controller.

Parameters:
- WORD_AW, 10, word-address width; memory holds 2^WORD_AW 32-bit words (default 4 KiB, byte addresses 0x0000-0x0FFF).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- pc  input  32  PC of the current instruction; used only for the write log
- addr  input  32  byte address (ALU output C)
- wdata  input  32  store data (rt value); low bits used for sh/sb
- we  input  1  store enable from the controller
- mem_op  input  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101-111 reserved
- rdata  output  32  extended load result
- align_err  output  1  access misaligned for its mem_op
- range_err  output  1  addr outside the implemented memory

Behaviour:
- Storage: array of 2^WORD_AW 32-bit words, indexed by addr[WORD_AW+1:2]. Little-endian byte lanes: addr[1:0]=0 selects bits [7:0]; addr[1]=0 selects half [15:0].
- Reset (asynchronous, while reset=1):
  - every word is cleared to 0;
  - rdata=0, align_err=0, range_err=0 regardless of other inputs;
  - no write commits, including on a clk edge while reset is high.
- align_err (combinational): 1 when word op and addr[1:0]!=0, or half op and addr[0]=1. Byte ops never set it. Reserved mem_op sets align_err=1.
- range_err (combinational): 1 when addr[31:WORD_AW+2] is nonzero.
- Read path (combinational, zero latency; required for single-cycle operation):
  - out-of-range or misaligned access: rdata=0.
  - word: rdata = selected word.
  - half: the 16-bit half is zero-extended (001) or sign-extended from bit 15 (010).
  - byte: the 8-bit byte is zero-extended (011) or sign-extended from bit 7 (100).
- Write path (rising clk edge): commits only when we=1, reset=0, align_err=0 and range_err=0. Otherwise memory is unchanged.
  - word: whole word = wdata.
  - half: only the addressed half lane = wdata[15:0]; the other half is preserved.
  - byte: only the addressed byte lane = wdata[7:0]; the other three bytes are preserved.
- Read-during-write, same cycle and same address: rdata shows the old contents until the edge, then the new contents after it. There is no bypass.
- Write log: on every committed write, $display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, new_word). new_word is the full 32-bit word after the merge. The log is simulation-only and not synthesised.
- Rejected writes (misaligned, out of range, reserved op) produce no log line and no state change. The controller decides any exception handling from the flags.
- The full 32-bit addr is decoded; upper bits are never silently wrapped into range.

Test Plan:
1. Assert reset mid-run after prior stores; release; read addr 0x10 with mem_op=000 -> rdata=0x00000000, no log lines while reset is high, even with we=1 and clk toggling.
2. sw 0x12345678 at 0x20, then lb at 0x20/0x21/0x22/0x23 with mem_op=011 -> 0x78/0x56/0x34/0x12. lh at 0x22 with mem_op=010 -> 0x00001234. Log line "@<pc>: *00000020 <= 12345678".
3. sw 0x00000000 at 0x40; sb 0xFFFFFF80 at 0x41 -> word 0x00008000. lb at 0x41 with mem_op=100 -> 0xFFFFFF80; mem_op=011 -> 0x00000080. Log shows the merged word 00008000.
4. sh 0xABCD at 0x42 over word 0x11112222 -> 0xABCD2222. lh at 0x42 with mem_op=010 -> 0xFFFFABCD.
5. sw with addr 0x22 -> align_err=1, memory unchanged, no log. lh with addr 0x21 -> align_err=1, rdata=0. lb with addr 0x21 -> align_err=0.
6. sw with addr 0x00001000 -> range_err=1, word 0 unchanged, no log. Same cycle sw and lw at 0x30 -> rdata shows the old value before the edge and the new value after it.
